// File: rtl/opmem_ctrl_pkg.sv
// Shared constants for the operand-memory load/fetch controller.
// Holds the FSM state encodings and the default geometry of the 8x8 opmem.
package opmem_ctrl_pkg;

   localparam int DW_DEF    = 8;
   localparam int AW_DEF    = 3;
   localparam int DEPTH_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_FETCH = 2'd2;

endpackage

// File: rtl/opmem_skid2.sv
// Two-entry FIFO that absorbs the registered read data of the opmem.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module opmem_skid2
   import opmem_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [1:0]    level
);

   logic       wr_idx_reg;
   logic       rd_idx_reg;
   logic [1:0] level_reg;
   logic       push_ok;
   logic       pop_ok;

   assign full    = (level_reg == 2'd2);
   assign empty   = (level_reg == 2'd0);
   assign level   = level_reg;
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [DW-1:0] data_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_reg <= '0;
            end else if (push_ok && (wr_idx_reg == 1'(gi))) begin
               data_reg <= din;
            end
         end
      end
   endgenerate

   assign dout = rd_idx_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_reg <= 1'b0;
         rd_idx_reg <= 1'b0;
         level_reg  <= 2'd0;
      end else begin
         if (push_ok) wr_idx_reg <= !wr_idx_reg;
         if (pop_ok)  rd_idx_reg <= !rd_idx_reg;
         level_reg <= level_reg + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/opmem_ctrl.sv
// Load/fetch controller in front of the single-port operand memory.
// LOAD writes a byte stream sequentially; FETCH replays it through a 2-entry skid buffer.
module opmem_ctrl
   import opmem_ctrl_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load_start,
   input  logic          run_start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   count,
   output logic          mem_ce,
   output logic          mem_oce,
   output logic          mem_reset,
   output logic          mem_wre,
   output logic [AW-1:0] mem_ad,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LAST_C  = (AW+1)'(DEPTH-1);
   localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
   localparam logic [AW-1:0] WR_ONE  = AW'(1);

   state_t        state_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW:0]   rd_ptr_reg;
   logic [AW:0]   pop_cnt_reg;
   logic [AW:0]   count_reg;
   logic          inflight_reg;
   logic          done_reg;

   logic          in_hs;
   logic          load_exit;
   logic          issue;
   logic          pop;
   logic          fetch_exit;
   logic          skid_full;
   logic          skid_empty;
   logic [1:0]    skid_level;
   logic [2:0]    occ;

   assign in_ready   = (state_reg == ST_LOAD);
   assign in_hs      = in_ready && in_valid;
   assign load_exit  = in_hs && (in_last || (count_reg == LAST_C));
   assign out_valid  = !skid_empty;
   assign pop        = out_valid && out_ready;
   assign occ        = {1'b0, skid_level} + {2'b00, inflight_reg};

   // The head leaving this cycle frees a slot, so a read may issue alongside it;
   // this keeps one byte per cycle while buffered plus in-flight never exceeds two.
   assign issue      = (state_reg == ST_FETCH) && (rd_ptr_reg < count_reg) &&
                       (occ < (3'd2 + {2'b00, pop})) && !(skid_full && !pop);
   assign fetch_exit = (state_reg == ST_FETCH) && pop && (pop_cnt_reg == (count_reg - ONE_C));

   assign busy      = (state_reg != ST_IDLE);
   assign done      = done_reg;
   assign count     = count_reg;
   assign mem_oce   = 1'b1;
   assign mem_reset = 1'b0;

   always_comb begin
      mem_ce  = 1'b0;
      mem_wre = 1'b0;
      mem_ad  = '0;
      mem_din = '0;
      if (in_hs) begin
         mem_ce  = 1'b1;
         mem_wre = 1'b1;
         mem_ad  = wr_ptr_reg;
         mem_din = in_data;
      end else if (issue) begin
         mem_ce  = 1'b1;
         mem_ad  = rd_ptr_reg[AW-1:0];
      end
   end

   opmem_skid2 #(
      .DW (DW)
   ) u_skid (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (inflight_reg),
      .din   (mem_dout),
      .pop   (pop),
      .dout  (out_data),
      .full  (skid_full),
      .empty (skid_empty),
      .level (skid_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         pop_cnt_reg  <= '0;
         count_reg    <= '0;
         inflight_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg     <= 1'b0;
         inflight_reg <= issue;
         case (state_reg)
            ST_IDLE: begin
               if (load_start) begin
                  state_reg  <= ST_LOAD;
                  wr_ptr_reg <= '0;
                  count_reg  <= '0;
               end else if (run_start) begin
                  if (count_reg != '0) begin
                     state_reg   <= ST_FETCH;
                     rd_ptr_reg  <= '0;
                     pop_cnt_reg <= '0;
                  end else begin
                     done_reg <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (in_hs) begin
                  wr_ptr_reg <= wr_ptr_reg + WR_ONE;
                  if (count_reg != DEPTH_C) count_reg <= count_reg + ONE_C;
               end
               if (load_exit) begin
                  state_reg <= ST_IDLE;
                  done_reg  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (issue) rd_ptr_reg  <= rd_ptr_reg + ONE_C;
               if (pop)   pop_cnt_reg <= pop_cnt_reg + ONE_C;
               if (fetch_exit) begin
                  state_reg <= ST_IDLE;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_opmem_ctrl.sv
// Directed bench for opmem_ctrl with a behavioural 8x8 registered-read RAM attached.
// Each step checks outputs on the falling edge against hand-computed values.
module tb_opmem_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          load_start = 1'b0;
   logic          run_start = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          done;
   logic [AW:0]   count;
   logic          mem_ce;
   logic          mem_oce;
   logic          mem_reset;
   logic          mem_wre;
   logic [AW-1:0] mem_ad;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   int n_checks = 0;
   int n_fail   = 0;

   opmem_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_start (load_start),
      .run_start  (run_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .count      (count),
      .mem_ce     (mem_ce),
      .mem_oce    (mem_oce),
      .mem_reset  (mem_reset),
      .mem_wre    (mem_wre),
      .mem_ad     (mem_ad),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one cycle of read latency.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_wre) ram[mem_ad] <= mem_din;
         else         mem_dout    <= ram[mem_ad];
      end
   end

   // Stream monitor: handshakes and reads that will occur at the coming rising edge.
   logic [DW-1:0] got_q [$];
   int issued = 0;
   int popped = 0;
   int done_cnt = 0;
   int max_occ = 0;
   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            popped++;
         end
         if (mem_ce && !mem_wre) issued++;
         if (done) done_cnt++;
         if (issued - popped > max_occ) max_occ = issued - popped;
      end
   end

   logic [DW-1:0] vec [9];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Loads n bytes from vec; exp_acc of them should be written, then a stall with done.
   task automatic do_load(input int n, input int last_idx, input int exp_acc, input int exp_count);
      int d0;
      d0 = done_cnt;
      load_start = 1'b1;
      next();
      load_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = vec[i];
         in_last  = (i == last_idx);
         @(negedge clk);
         if (i < exp_acc) begin
            check("ld_ready", in_ready, 1);
            check("ld_ce_wre", {mem_ce, mem_wre}, 2'b11);
            check("ld_ad", mem_ad, i);
            check("ld_din", mem_din, vec[i]);
            check("ld_nodone", done, 0);
         end else begin
            check("ld_stall_ready", in_ready, 0);
            check("ld_stall_ce", mem_ce, 0);
            check("ld_done", done, 1);
         end
         next();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check("ld_done_end", done, 0);
      check("ld_count", count, exp_count);
      check("ld_busy", busy, 0);
      check("ld_done_once", done_cnt - d0, 1);
      next();
   endtask

   initial begin
      int base, iss0, d0, p0;
      bit fin;

      // Reset state
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      check("rst_mem", {mem_ce, mem_wre, mem_ad, mem_din}, 0);
      check("rst_const", {mem_oce, mem_reset}, 2'b10);
      reset_n = 1'b1;
      next();

      // Test 5: run_start with nothing stored
      run_start = 1'b1;
      @(negedge clk);
      check("t5_pre_done", done, 0);
      check("t5_pre_ce", mem_ce, 0);
      next();
      run_start = 1'b0;
      @(negedge clk);
      check("t5_done", done, 1);
      check("t5_busy", busy, 0);
      check("t5_out_valid", out_valid, 0);
      check("t5_ce", mem_ce, 0);
      next();
      @(negedge clk);
      check("t5_done_end", done, 0);
      next();

      // Test 1: load A1,B2,C3 with in_last on C3; DD offered afterwards is refused
      vec[0] = 8'hA1; vec[1] = 8'hB2; vec[2] = 8'hC3; vec[3] = 8'hDD;
      do_load(4, 2, 3, 3);

      // Test 3: fetch three bytes with out_ready held high
      run_start = 1'b1;
      out_ready = 1'b1;
      next();
      run_start = 1'b0;
      @(negedge clk);
      check("t3_busy", busy, 1);
      check("t3_lat1", out_valid, 0);
      check("t3_rd0", {mem_ce, mem_wre, mem_ad}, {2'b10, 3'd0});
      next();
      @(negedge clk);
      check("t3_lat2", out_valid, 0);
      check("t3_rd1", {mem_ce, mem_wre, mem_ad}, {2'b10, 3'd1});
      next();
      @(negedge clk);
      check("t3_b0", {out_valid, out_data}, {1'b1, 8'hA1});
      check("t3_rd2", {mem_ce, mem_wre, mem_ad}, {2'b10, 3'd2});
      next();
      @(negedge clk);
      check("t3_b1", {out_valid, out_data}, {1'b1, 8'hB2});
      check("t3_no_rd", mem_ce, 0);
      next();
      @(negedge clk);
      check("t3_b2", {out_valid, out_data}, {1'b1, 8'hC3});
      check("t3_nodone", done, 0);
      next();
      @(negedge clk);
      check("t3_done", done, 1);
      check("t3_idle", {busy, out_valid}, 2'b00);
      check("t3_count_kept", count, 3);
      next();

      // Test 2: nine bytes without in_last, only eight fit
      vec[0] = 8'h10; vec[1] = 8'h21; vec[2] = 8'h32; vec[3] = 8'h43;
      vec[4] = 8'h54; vec[5] = 8'h65; vec[6] = 8'h76; vec[7] = 8'h87;
      vec[8] = 8'h98;
      do_load(9, -1, 8, 8);

      // Test 4: fetch eight with out_ready low for five cycles mid-stream
      base = got_q.size();
      iss0 = issued;
      d0   = done_cnt;
      fin  = 1'b0;
      run_start = 1'b1;
      out_ready = 1'b1;
      next();
      run_start = 1'b0;
      for (int c = 0; c < 60 && !fin; c++) begin
         out_ready = !(c >= 4 && c < 9);
         @(negedge clk);
         if (done) fin = 1'b1;
         next();
      end
      out_ready = 1'b1;
      check("t4_finished", fin, 1);
      check("t4_nbytes", got_q.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         check("t4_byte", (base + i < got_q.size()) ? got_q[base + i] : 8'hxx, vec[i]);
      end
      check("t4_occ_le2", (max_occ <= 2), 1);
      check("t4_reads", issued - iss0, 8);
      check("t4_done_once", done_cnt - d0, 1);

      // Test 6: reset in the middle of a fetch after three bytes
      base = got_q.size();
      p0   = popped;
      fin  = 1'b0;
      run_start = 1'b1;
      next();
      run_start = 1'b0;
      for (int c = 0; c < 20 && !fin; c++) begin
         @(posedge clk);
         if (popped - p0 >= 3) fin = 1'b1;
      end
      check("t6_reached", fin, 1);
      check("t6_third", (base + 2 < got_q.size()) ? got_q[base + 2] : 8'hxx, 8'h32);
      #2 reset_n = 1'b0;
      #1;
      check("t6_out", {out_valid, out_data}, 0);
      check("t6_busy_done", {busy, done, in_ready}, 3'b000);
      check("t6_count", count, 0);
      check("t6_mem", {mem_ce, mem_wre, mem_ad, mem_din}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      next();
      run_start = 1'b1;
      next();
      run_start = 1'b0;
      @(negedge clk);
      check("t6_rerun_done", done, 1);
      check("t6_rerun_idle", {busy, out_valid, mem_ce}, 3'b000);
      next();
      @(negedge clk);
      check("t6_rerun_quiet", {done, out_valid, mem_ce}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
